// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction fetch stage: PC source select and fetch FSM states.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        NEXTPC     = 2'd0,
        ALU_RESULT = 2'd1,
        NOP_PC_MUX = 2'd2
    } pc_mux;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_WAIT = 2'd1,
        F_HOLD = 2'd2
    } fetch_state_e;

    localparam int INSTR_WIDTH = 32;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc} holding register that parks a fetched word while decode is stalled.
module fetch_skid_buffer
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_load,
    input  logic                   i_drain,
    input  logic                   i_clear,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    input  logic [ADDR_WIDTH-1:0]  i_pc,
    output logic                   o_full,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0]  o_pc
);

    logic                   r_full;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [ADDR_WIDTH-1:0]  r_pc;

    // Clear wins over load so a redirect never leaves a stale word parked.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_full  <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full  <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_drain) begin
            r_full <= 1'b0;
        end
    end

    assign o_full  = r_full;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, keeps one imem request outstanding and drives the IF/ID register.
// Handshake: imem_req_op is a one-cycle strobe; the single response arrives on imem_rvalid_ip >=1 cycle later.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall_ip,
    input  logic                   flush_ip,
    input  pc_mux                  pc_mux_ip,
    input  logic [ADDR_WIDTH-1:0]  branch_target_ip,
    output logic                   imem_req_op,
    output logic [ADDR_WIDTH-1:0]  imem_addr_op,
    input  logic                   imem_rvalid_ip,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_ip,
    output logic                   instr_data_valid_op,
    output logic [INSTR_WIDTH-1:0] instr_data_op,
    output logic [ADDR_WIDTH-1:0]  pc_op,
    output logic [ADDR_WIDTH-1:0]  pc4_op,
    output fetch_state_e           debug_state_op
);

    fetch_state_e           r_state;
    fetch_state_e           w_next_state;
    logic [ADDR_WIDTH-1:0]  r_pc;
    logic                   r_discard;
    logic                   r_valid;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [ADDR_WIDTH-1:0]  r_pc_out;
    logic [ADDR_WIDTH-1:0]  r_pc4_out;

    logic                   w_jump;
    logic                   w_redirect;
    logic                   w_rsp;
    logic                   w_deliver;
    logic                   w_capture;
    logic                   w_drain;
    logic [ADDR_WIDTH-1:0]  w_pc_plus4;
    logic [ADDR_WIDTH-1:0]  w_target;
    logic                   w_buf_full;
    logic [INSTR_WIDTH-1:0] w_buf_instr;
    logic [ADDR_WIDTH-1:0]  w_buf_pc;

    assign w_jump     = (pc_mux_ip == ALU_RESULT);
    assign w_redirect = w_jump | flush_ip;
    assign w_rsp      = (r_state == F_WAIT) && imem_rvalid_ip;
    assign w_pc_plus4 = r_pc + ADDR_WIDTH'(4);
    assign w_target   = branch_target_ip & ~ADDR_WIDTH'(3);

    always_ff @(posedge clock) begin
        if (reset) r_state <= F_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            F_IDLE: w_next_state = F_WAIT;
            F_WAIT: begin
                if (imem_rvalid_ip) begin
                    if (w_redirect || r_discard) w_next_state = F_IDLE;
                    else if (stall_ip)           w_next_state = F_HOLD;
                end
            end
            F_HOLD: if (w_redirect || !stall_ip) w_next_state = F_IDLE;
            default: w_next_state = F_IDLE;
        endcase
    end

    // Delivering a word re-issues immediately at pc+4, which is what keeps a 1-cycle memory at full rate.
    always_comb begin
        w_deliver    = w_rsp && !r_discard && !stall_ip && !w_redirect;
        w_capture    = w_rsp && !r_discard && stall_ip && !w_redirect;
        w_drain      = (r_state == F_HOLD) && w_buf_full && !stall_ip && !w_redirect;
        imem_req_op  = 1'b0;
        imem_addr_op = r_pc;
        if (!reset) begin
            if (r_state == F_IDLE) begin
                imem_req_op = 1'b1;
            end else if (w_deliver) begin
                imem_req_op  = 1'b1;
                imem_addr_op = w_pc_plus4;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc      <= BOOT_ADDR;
            r_discard <= 1'b0;
            r_valid   <= 1'b0;
            r_instr   <= '0;
            r_pc_out  <= '0;
            r_pc4_out <= '0;
        end else begin
            if (w_jump)                      r_pc <= w_target;
            else if (w_deliver || w_capture) r_pc <= w_pc_plus4;

            // A request already in flight (or issuing now) must have its response dropped.
            if (w_redirect && ((r_state == F_IDLE) || ((r_state == F_WAIT) && !imem_rvalid_ip)))
                r_discard <= 1'b1;
            else if (w_rsp)
                r_discard <= 1'b0;

            if (w_redirect) begin
                r_valid <= 1'b0;
            end else if (w_deliver) begin
                r_valid   <= 1'b1;
                r_instr   <= imem_rdata_ip;
                r_pc_out  <= r_pc;
                r_pc4_out <= w_pc_plus4;
            end else if (w_drain) begin
                r_valid   <= 1'b1;
                r_instr   <= w_buf_instr;
                r_pc_out  <= w_buf_pc;
                r_pc4_out <= w_buf_pc + ADDR_WIDTH'(4);
            end else if (!stall_ip) begin
                r_valid <= 1'b0;
            end
        end
    end

    fetch_skid_buffer #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_skid (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_capture),
        .i_drain (w_drain),
        .i_clear (w_redirect),
        .i_instr (imem_rdata_ip),
        .i_pc    (r_pc),
        .o_full  (w_buf_full),
        .o_instr (w_buf_instr),
        .o_pc    (w_buf_pc)
    );

    assign instr_data_valid_op = r_valid;
    assign instr_data_op       = r_instr;
    assign pc_op               = r_pc_out;
    assign pc4_op              = r_pc4_out;
    assign debug_state_op      = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: two instances (boot 0 and boot 0xFFFF_FFFC) each fed by a latency-configurable memory.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall_ip = 1'b0;
    logic        flush_ip = 1'b0;
    pc_mux       pc_mux_ip = NEXTPC;
    logic [31:0] branch_target_ip = '0;

    logic         req_a, rvalid_a, valid_a;
    logic [31:0]  addr_a, rdata_a, instr_a, pc_a, pc4_a;
    fetch_state_e state_a;
    logic         req_b, rvalid_b, valid_b;
    logic [31:0]  addr_b, rdata_b, instr_b, pc_b, pc4_b;
    fetch_state_e state_b;

    int mem_lat = 1;
    int n_checks = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    fetch_stage #(.ADDR_WIDTH(32), .BOOT_ADDR(32'h0000_0000)) dut_a (
        .clock(clock), .reset(reset), .stall_ip(stall_ip), .flush_ip(flush_ip),
        .pc_mux_ip(pc_mux_ip), .branch_target_ip(branch_target_ip),
        .imem_req_op(req_a), .imem_addr_op(addr_a), .imem_rvalid_ip(rvalid_a), .imem_rdata_ip(rdata_a),
        .instr_data_valid_op(valid_a), .instr_data_op(instr_a), .pc_op(pc_a), .pc4_op(pc4_a),
        .debug_state_op(state_a)
    );

    fetch_stage #(.ADDR_WIDTH(32), .BOOT_ADDR(32'hFFFF_FFFC)) dut_b (
        .clock(clock), .reset(reset), .stall_ip(stall_ip), .flush_ip(flush_ip),
        .pc_mux_ip(pc_mux_ip), .branch_target_ip(branch_target_ip),
        .imem_req_op(req_b), .imem_addr_op(addr_b), .imem_rvalid_ip(rvalid_b), .imem_rdata_ip(rdata_b),
        .instr_data_valid_op(valid_b), .instr_data_op(instr_b), .pc_op(pc_b), .pc4_op(pc4_b),
        .debug_state_op(state_b)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory models: respond mem_lat cycles after the request edge with an address-derived word.
    logic        pend_a, pend_b;
    logic [31:0] paddr_a, paddr_b;
    int          cnt_a, cnt_b;

    always @(posedge clock) begin
        if (reset) begin
            rvalid_a <= 1'b0;
            pend_a   <= 1'b0;
        end else begin
            rvalid_a <= 1'b0;
            if (pend_a) begin
                if (cnt_a <= 1) begin
                    rvalid_a <= 1'b1;
                    rdata_a  <= mem_word(paddr_a);
                    pend_a   <= 1'b0;
                end else cnt_a <= cnt_a - 1;
            end
            if (req_a) begin
                if (mem_lat <= 1) begin
                    rvalid_a <= 1'b1;
                    rdata_a  <= mem_word(addr_a);
                end else begin
                    pend_a  <= 1'b1;
                    paddr_a <= addr_a;
                    cnt_a   <= mem_lat - 1;
                end
            end
        end
    end

    always @(posedge clock) begin
        if (reset) begin
            rvalid_b <= 1'b0;
            pend_b   <= 1'b0;
        end else begin
            rvalid_b <= 1'b0;
            if (pend_b) begin
                if (cnt_b <= 1) begin
                    rvalid_b <= 1'b1;
                    rdata_b  <= mem_word(paddr_b);
                    pend_b   <= 1'b0;
                end else cnt_b <= cnt_b - 1;
            end
            if (req_b) begin
                if (mem_lat <= 1) begin
                    rvalid_b <= 1'b1;
                    rdata_b  <= mem_word(addr_b);
                end else begin
                    pend_b  <= 1'b1;
                    paddr_b <= addr_b;
                    cnt_b   <= mem_lat - 1;
                end
            end
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset(input int lat);
        @(negedge clock);
        reset = 1'b1;
        stall_ip = 1'b0;
        flush_ip = 1'b0;
        pc_mux_ip = NEXTPC;
        branch_target_ip = '0;
        mem_lat = lat;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        n_checks++; if (valid_a !== 1'b0) $display("FAIL rst_valid: got %b want 0", valid_a); else n_pass++;
        n_checks++; if (instr_a !== 32'h0) $display("FAIL rst_instr: got %h want 0", instr_a); else n_pass++;
        n_checks++; if (pc_a !== 32'h0) $display("FAIL rst_pc: got %h want 0", pc_a); else n_pass++;
        n_checks++; if (pc4_a !== 32'h0) $display("FAIL rst_pc4: got %h want 0", pc4_a); else n_pass++;
        n_checks++; if (req_a !== 1'b0) $display("FAIL rst_req_forced: got %b want 0", req_a); else n_pass++;
        n_checks++; if (state_a !== F_IDLE) $display("FAIL rst_state: got %0d want %0d", state_a, F_IDLE); else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++; if (req_a !== 1'b1) $display("FAIL rst_first_req: got %b want 1", req_a); else n_pass++;
        n_checks++; if (addr_a !== 32'h0) $display("FAIL rst_first_addr: got %h want 0", addr_a); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_addr, exp_pc;
        do_reset(1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            exp_addr = 32'(4 * k);
            n_checks++; if (req_a !== 1'b1) $display("FAIL b2b_req[%0d]: got %b want 1", k, req_a); else n_pass++;
            n_checks++; if (addr_a !== exp_addr) $display("FAIL b2b_addr[%0d]: got %h want %h", k, addr_a, exp_addr); else n_pass++;
            if (k < 2) begin
                n_checks++; if (valid_a !== 1'b0) $display("FAIL b2b_bubble[%0d]: got %b want 0", k, valid_a); else n_pass++;
            end else begin
                exp_pc = 32'(4 * (k - 2));
                n_checks++; if (valid_a !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b want 1", k, valid_a); else n_pass++;
                n_checks++; if (pc_a !== exp_pc) $display("FAIL b2b_pc[%0d]: got %h want %h", k, pc_a, exp_pc); else n_pass++;
                n_checks++; if (pc4_a !== exp_pc + 32'd4) $display("FAIL b2b_pc4[%0d]: got %h want %h", k, pc4_a, exp_pc + 32'd4); else n_pass++;
                n_checks++; if (instr_a !== mem_word(exp_pc)) $display("FAIL b2b_instr[%0d]: got %h want %h", k, instr_a, mem_word(exp_pc)); else n_pass++;
            end
        end
    endtask

    task automatic test_stall();
        do_reset(1);
        repeat (3) step();
        n_checks++; if (pc_a !== 32'h4 || valid_a !== 1'b1) $display("FAIL stall_pre: got pc %h v %b want pc 4 v 1", pc_a, valid_a); else n_pass++;
        stall_ip = 1'b1;
        #1;
        n_checks++; if (req_a !== 1'b0) $display("FAIL stall_capture_noreq: got %b want 0", req_a); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            step();
            if (k == 2) stall_ip = 1'b0;
            n_checks++; if (pc_a !== 32'h4 || valid_a !== 1'b1 || pc4_a !== 32'h8) $display("FAIL stall_hold[%0d]: got pc %h pc4 %h v %b want pc 4 pc4 8 v 1", k, pc_a, pc4_a, valid_a); else n_pass++;
            n_checks++; if (state_a !== F_HOLD) $display("FAIL stall_state[%0d]: got %0d want %0d", k, state_a, F_HOLD); else n_pass++;
        end
        step();
        n_checks++; if (pc_a !== 32'h8 || valid_a !== 1'b1) $display("FAIL stall_release_pc: got pc %h v %b want pc 8 v 1", pc_a, valid_a); else n_pass++;
        n_checks++; if (instr_a !== mem_word(32'h8)) $display("FAIL stall_release_instr: got %h want %h", instr_a, mem_word(32'h8)); else n_pass++;
        n_checks++; if (pc4_a !== 32'hC) $display("FAIL stall_release_pc4: got %h want c", pc4_a); else n_pass++;
        n_checks++; if (req_a !== 1'b1 || addr_a !== 32'hC) $display("FAIL stall_resume_req: got req %b addr %h want req 1 addr c", req_a, addr_a); else n_pass++;
        step();
        n_checks++; if (valid_a !== 1'b0) $display("FAIL stall_gap_bubble: got %b want 0", valid_a); else n_pass++;
        step();
        n_checks++; if (pc_a !== 32'hC || valid_a !== 1'b1) $display("FAIL stall_next_pc: got pc %h v %b want pc c v 1", pc_a, valid_a); else n_pass++;
    endtask

    task automatic test_redirect_wait();
        do_reset(3);
        step();
        pc_mux_ip = ALU_RESULT;
        branch_target_ip = 32'h0000_0103;
        #1;
        n_checks++; if (req_a !== 1'b0) $display("FAIL rdw_noreq: got %b want 0", req_a); else n_pass++;
        step();
        pc_mux_ip = NEXTPC;
        n_checks++; if (valid_a !== 1'b0) $display("FAIL rdw_valid_c2: got %b want 0", valid_a); else n_pass++;
        step();
        n_checks++; if (req_a !== 1'b0) $display("FAIL rdw_stale_dropped_req: got %b want 0", req_a); else n_pass++;
        n_checks++; if (valid_a !== 1'b0) $display("FAIL rdw_valid_c3: got %b want 0", valid_a); else n_pass++;
        step();
        n_checks++; if (req_a !== 1'b1 || addr_a !== 32'h100) $display("FAIL rdw_target_req: got req %b addr %h want req 1 addr 100", req_a, addr_a); else n_pass++;
        n_checks++; if (valid_a !== 1'b0) $display("FAIL rdw_valid_c4: got %b want 0", valid_a); else n_pass++;
        repeat (3) step();
        n_checks++; if (valid_a !== 1'b0) $display("FAIL rdw_valid_c7: got %b want 0", valid_a); else n_pass++;
        step();
        n_checks++; if (valid_a !== 1'b1 || pc_a !== 32'h100) $display("FAIL rdw_target_pc: got pc %h v %b want pc 100 v 1", pc_a, valid_a); else n_pass++;
        n_checks++; if (pc4_a !== 32'h104) $display("FAIL rdw_target_pc4: got %h want 104", pc4_a); else n_pass++;
        n_checks++; if (instr_a !== mem_word(32'h100)) $display("FAIL rdw_target_instr: got %h want %h", instr_a, mem_word(32'h100)); else n_pass++;
    endtask

    task automatic test_redirect_rvalid();
        do_reset(1);
        repeat (2) step();
        n_checks++; if (valid_a !== 1'b1 || pc_a !== 32'h0) $display("FAIL rdr_pre: got pc %h v %b want pc 0 v 1", pc_a, valid_a); else n_pass++;
        pc_mux_ip = ALU_RESULT;
        branch_target_ip = 32'h0000_0100;
        #1;
        n_checks++; if (req_a !== 1'b0) $display("FAIL rdr_noreq: got %b want 0", req_a); else n_pass++;
        step();
        pc_mux_ip = NEXTPC;
        n_checks++; if (valid_a !== 1'b0) $display("FAIL rdr_word_dropped: got %b want 0", valid_a); else n_pass++;
        n_checks++; if (req_a !== 1'b1 || addr_a !== 32'h100) $display("FAIL rdr_target_req: got req %b addr %h want req 1 addr 100", req_a, addr_a); else n_pass++;
        step();
        n_checks++; if (valid_a !== 1'b0) $display("FAIL rdr_valid_c4: got %b want 0", valid_a); else n_pass++;
        step();
        n_checks++; if (valid_a !== 1'b1 || pc_a !== 32'h100) $display("FAIL rdr_target_pc: got pc %h v %b want pc 100 v 1", pc_a, valid_a); else n_pass++;
        n_checks++; if (instr_a !== mem_word(32'h100)) $display("FAIL rdr_target_instr: got %h want %h", instr_a, mem_word(32'h100)); else n_pass++;
    endtask

    task automatic test_redirect_hold();
        do_reset(1);
        repeat (2) step();
        stall_ip = 1'b1;
        step();
        n_checks++; if (state_a !== F_HOLD) $display("FAIL rdh_state_hold: got %0d want %0d", state_a, F_HOLD); else n_pass++;
        n_checks++; if (valid_a !== 1'b1 || pc_a !== 32'h0) $display("FAIL rdh_frozen: got pc %h v %b want pc 0 v 1", pc_a, valid_a); else n_pass++;
        pc_mux_ip = ALU_RESULT;
        branch_target_ip = 32'h0000_0200;
        #1;
        n_checks++; if (req_a !== 1'b0) $display("FAIL rdh_noreq: got %b want 0", req_a); else n_pass++;
        step();
        pc_mux_ip = NEXTPC;
        stall_ip = 1'b0;
        #1;
        n_checks++; if (valid_a !== 1'b0) $display("FAIL rdh_valid_cleared: got %b want 0", valid_a); else n_pass++;
        n_checks++; if (state_a !== F_IDLE) $display("FAIL rdh_state_idle: got %0d want %0d", state_a, F_IDLE); else n_pass++;
        n_checks++; if (req_a !== 1'b1 || addr_a !== 32'h200) $display("FAIL rdh_target_req: got req %b addr %h want req 1 addr 200", req_a, addr_a); else n_pass++;
        step();
        n_checks++; if (valid_a !== 1'b0) $display("FAIL rdh_no_held_word: got %b want 0", valid_a); else n_pass++;
        step();
        n_checks++; if (valid_a !== 1'b1 || pc_a !== 32'h200) $display("FAIL rdh_target_pc: got pc %h v %b want pc 200 v 1", pc_a, valid_a); else n_pass++;
        n_checks++; if (instr_a !== mem_word(32'h200)) $display("FAIL rdh_target_instr: got %h want %h", instr_a, mem_word(32'h200)); else n_pass++;
    endtask

    task automatic test_flush_keeps_pc();
        do_reset(1);
        repeat (2) step();
        flush_ip = 1'b1;
        branch_target_ip = 32'h0000_0300;
        #1;
        n_checks++; if (req_a !== 1'b0) $display("FAIL flush_noreq: got %b want 0", req_a); else n_pass++;
        step();
        flush_ip = 1'b0;
        n_checks++; if (valid_a !== 1'b0) $display("FAIL flush_valid: got %b want 0", valid_a); else n_pass++;
        n_checks++; if (req_a !== 1'b1 || addr_a !== 32'h4) $display("FAIL flush_refetch: got req %b addr %h want req 1 addr 4", req_a, addr_a); else n_pass++;
        repeat (2) step();
        n_checks++; if (valid_a !== 1'b1 || pc_a !== 32'h4) $display("FAIL flush_pc: got pc %h v %b want pc 4 v 1", pc_a, valid_a); else n_pass++;
        n_checks++; if (instr_a !== mem_word(32'h4)) $display("FAIL flush_instr: got %h want %h", instr_a, mem_word(32'h4)); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset(1);
        n_checks++; if (req_b !== 1'b1 || addr_b !== 32'hFFFF_FFFC) $display("FAIL wrap_first_addr: got req %b addr %h want req 1 addr fffffffc", req_b, addr_b); else n_pass++;
        step();
        n_checks++; if (req_b !== 1'b1 || addr_b !== 32'h0) $display("FAIL wrap_second_addr: got req %b addr %h want req 1 addr 0", req_b, addr_b); else n_pass++;
        step();
        n_checks++; if (valid_b !== 1'b1 || pc_b !== 32'hFFFF_FFFC) $display("FAIL wrap_first_pc: got pc %h v %b want pc fffffffc v 1", pc_b, valid_b); else n_pass++;
        n_checks++; if (pc4_b !== 32'h0) $display("FAIL wrap_first_pc4: got %h want 0", pc4_b); else n_pass++;
        step();
        n_checks++; if (valid_b !== 1'b1 || pc_b !== 32'h0) $display("FAIL wrap_second_pc: got pc %h v %b want pc 0 v 1", pc_b, valid_b); else n_pass++;
        n_checks++; if (pc4_b !== 32'h4) $display("FAIL wrap_second_pc4: got %h want 4", pc4_b); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_redirect_hold();
        test_flush_keeps_pc();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
